// File: rtl/core_pkg.sv
// core_pkg: shared widths, result-select and funct3 encodings, MEM-stage FSM states
package core_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR = 5;
  localparam logic [1:0] ALU_RESULT = 2'b00;
  localparam logic [1:0] MEM_TO_REG = 2'b01;
  localparam logic [1:0] PC_PLUS = 2'b10;
  localparam logic [2:0] F3_LB = 3'b000;
  localparam logic [2:0] F3_LH = 3'b001;
  localparam logic [2:0] F3_LW = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  typedef enum logic {IDLE, BUS} mem_state_t;
endpackage

// File: rtl/stage_memory_if.sv
// stage_memory_if: req/ack data bus between the MEM stage and memory
interface stage_memory_if #(parameter int XLEN = 32);
  logic req;
  logic we;
  logic ack;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic [XLEN/8-1:0] be;
  modport master(output req, we, addr, wdata, be, input ack, rdata);
  modport slave(input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: store lane steering, misalignment detect and load extension
module lsu_align
  import core_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] st_data,
  input  logic [1:0]  ld_off,
  input  logic [2:0]  ld_funct3,
  input  logic [31:0] ld_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_ext,
  output logic        misaligned
);
  logic [7:0] ld_byte;
  logic [15:0] ld_half;
  always_comb begin
    be = st_funct3[1:0] == SIZE_B ? 4'b0001 << st_off :
         st_funct3[1:0] == SIZE_H ? 4'b0011 << {st_off[1], 1'b0} : 4'b1111;
    wdata = st_funct3[1:0] == SIZE_B ? {4{st_data[7:0]}} :
            st_funct3[1:0] == SIZE_H ? {2{st_data[15:0]}} : st_data;
    misaligned = st_funct3[1:0] == SIZE_B ? 1'b0 :
                 st_funct3[1:0] == SIZE_H ? st_off[0] : |st_off;
    ld_byte = ld_data[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? ld_data[31:16] : ld_data[15:0];
    ld_ext = ld_funct3 == F3_LB  ? {{24{ld_byte[7]}}, ld_byte} :
             ld_funct3 == F3_LH  ? {{16{ld_half[15]}}, ld_half} :
             ld_funct3 == F3_LBU ? {24'b0, ld_byte} :
             ld_funct3 == F3_LHU ? {16'b0, ld_half} : ld_data;
  end
endmodule

// File: rtl/stage_memory.sv
// stage_memory: EX/MEM pipeline register plus a req/ack load/store unit
module stage_memory
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REG_ADDR = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  input  logic [REG_ADDR-1:0] ex_rd,
  input  logic [1:0]          ex_result_src,
  input  logic [XLEN-1:0]     ex_alu_result,
  input  logic [XLEN-1:0]     ex_write_data,
  input  logic                ex_mem_rd,
  input  logic                ex_mem_wr,
  input  logic [2:0]          ex_funct3,
  input  logic [XLEN-1:0]     ex_instr_addr_plus,
  input  logic                ex_regfile_wr_enable,
  output logic                mem_stall,
  stage_memory_if.master      dbus,
  output logic [REG_ADDR-1:0] mem_rd,
  output logic [1:0]          mem_result_src,
  output logic [XLEN-1:0]     mem_alu_result,
  output logic [XLEN-1:0]     mem_instr_addr_plus,
  output logic [XLEN-1:0]     mem_read_data,
  output logic                mem_regfile_wr_enable,
  output logic                mem_misaligned
);
  mem_state_t state;
  logic valid_q;
  logic wr_en_q;
  logic [2:0] funct3_q;
  logic [3:0] be_n;
  logic [31:0] wdata_n;
  logic [31:0] ld_ext;
  logic mis_n;
  logic is_mem;
  assign is_mem = ex_valid & (ex_mem_rd | ex_mem_wr);
  assign mem_regfile_wr_enable = state == IDLE && valid_q && wr_en_q && !mem_misaligned;
  lsu_align u_align (
    .st_off(ex_alu_result[1:0]),
    .st_funct3(ex_funct3),
    .st_data(ex_write_data),
    .ld_off(mem_alu_result[1:0]),
    .ld_funct3(funct3_q),
    .ld_data(dbus.rdata),
    .be(be_n),
    .wdata(wdata_n),
    .ld_ext(ld_ext),
    .misaligned(mis_n)
  );
  // The stage register only advances while IDLE; in BUS it holds the access being served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mem_stall <= 1'b0;
      valid_q <= 1'b0;
      wr_en_q <= 1'b0;
      funct3_q <= '0;
      mem_rd <= '0;
      mem_result_src <= '0;
      mem_alu_result <= '0;
      mem_instr_addr_plus <= '0;
      mem_read_data <= '0;
      mem_misaligned <= 1'b0;
      dbus.req <= 1'b0;
      dbus.we <= 1'b0;
      dbus.addr <= '0;
      dbus.wdata <= '0;
      dbus.be <= '0;
    end else if (state == BUS) begin
      if (dbus.ack) begin
        state <= IDLE;
        mem_stall <= 1'b0;
        dbus.req <= 1'b0;
        if (!dbus.we) mem_read_data <= ld_ext;
      end
    end else begin
      valid_q <= ex_valid;
      wr_en_q <= ex_regfile_wr_enable;
      funct3_q <= ex_funct3;
      mem_rd <= ex_rd;
      mem_result_src <= ex_result_src;
      mem_alu_result <= ex_alu_result;
      mem_instr_addr_plus <= ex_instr_addr_plus;
      mem_misaligned <= is_mem & mis_n;
      if (is_mem && !mis_n) begin
        state <= BUS;
        mem_stall <= 1'b1;
        dbus.req <= 1'b1;
        dbus.we <= ex_mem_wr;
        dbus.addr <= {ex_alu_result[XLEN-1:2], 2'b00};
        dbus.wdata <= wdata_n;
        dbus.be <= be_n;
      end
    end
  end
endmodule

// File: tb/tb_stage_memory.sv
// tb_stage_memory: directed and randomized checks of the MEM stage against a behavioural model
module tb_stage_memory;
  import core_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  logic ex_valid, ex_mem_rd, ex_mem_wr, ex_regfile_wr_enable;
  logic [4:0] ex_rd;
  logic [1:0] ex_result_src;
  logic [31:0] ex_alu_result, ex_write_data, ex_instr_addr_plus;
  logic [2:0] ex_funct3;
  logic mem_stall, mem_regfile_wr_enable, mem_misaligned;
  logic [4:0] mem_rd;
  logic [1:0] mem_result_src;
  logic [31:0] mem_alu_result, mem_instr_addr_plus, mem_read_data;
  stage_memory_if #(.XLEN(32)) dbus ();
  stage_memory dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_result_src(ex_result_src),
    .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_funct3(ex_funct3),
    .ex_instr_addr_plus(ex_instr_addr_plus), .ex_regfile_wr_enable(ex_regfile_wr_enable),
    .mem_stall(mem_stall), .dbus(dbus),
    .mem_rd(mem_rd), .mem_result_src(mem_result_src), .mem_alu_result(mem_alu_result),
    .mem_instr_addr_plus(mem_instr_addr_plus), .mem_read_data(mem_read_data),
    .mem_regfile_wr_enable(mem_regfile_wr_enable), .mem_misaligned(mem_misaligned)
  );
  int checks = 0;
  int passed = 0;
  logic [31:0] last_rd = 0;

  function automatic int ref_size(input logic [2:0] f3);
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction
  function automatic logic ref_mis(input logic [31:0] a, input logic [2:0] f3);
    return (a % ref_size(f3)) != 0;
  endfunction
  function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [2:0] f3);
    int sz = ref_size(f3);
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction
  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [2:0] f3);
    int sz = ref_size(f3);
    return sz == 1 ? (d & 32'hFF) * 32'h01010101 : sz == 2 ? (d & 32'hFFFF) * 32'h00010001 : d;
  endfunction
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] b = (d >> (8 * (a % 4))) & 32'hFF;
    logic [31:0] h = (d >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    case (f3)
      3'd0: return b >= 128 ? b - 256 : b;
      3'd1: return h >= 32768 ? h - 65536 : h;
      3'd4: return b;
      3'd5: return h;
      default: return d;
    endcase
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic set_ex(input logic v, input logic [4:0] rd, input logic [1:0] src, input logic [31:0] alu,
                        input logic [31:0] wd, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] pc4, input logic we);
    ex_valid = v; ex_rd = rd; ex_result_src = src; ex_alu_result = alu; ex_write_data = wd;
    ex_mem_rd = ld; ex_mem_wr = st; ex_funct3 = f3; ex_instr_addr_plus = pc4; ex_regfile_wr_enable = we;
  endtask
  task automatic bubble;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  // Serves an access already in BUS: acks on the lat-th BUS cycle, returns in the cycle after.
  task automatic run_txn(input int lat, input logic [31:0] rdata, output int stalls,
                         output logic stable, output logic wen_bus);
    logic [31:0] a0, w0;
    logic [3:0] b0;
    logic we0;
    a0 = dbus.addr; w0 = dbus.wdata; b0 = dbus.be; we0 = dbus.we;
    stalls = 0; stable = 1; wen_bus = 0;
    for (int i = 1; i <= lat + 4; i++) begin
      if (!mem_stall) break;
      stalls++;
      wen_bus |= mem_regfile_wr_enable;
      stable &= dbus.req && dbus.addr == a0 && dbus.wdata == w0 && dbus.be == b0 && dbus.we == we0;
      dbus.rdata = (i == lat) ? rdata : 32'h13572468;
      dbus.ack = (i == lat);
      step;
      dbus.ack = 0;
    end
  endtask

  task automatic test_reset;
    bubble;
    dbus.ack = 0; dbus.rdata = 0;
    rst_n = 0;
    step;
    checks++;
    if ({mem_stall, dbus.req, dbus.we, dbus.be, dbus.addr, mem_rd, mem_read_data, mem_alu_result,
         mem_regfile_wr_enable, mem_misaligned} !== '0)
      $display("FAIL reset: stall=%b req=%b rd=%0d rdata=%h wen=%b mis=%b", mem_stall, dbus.req,
               mem_rd, mem_read_data, mem_regfile_wr_enable, mem_misaligned);
    else passed++;
    rst_n = 1;
    step;
  endtask

  task automatic test_lw_latency;
    int stalls; logic stable, wb;
    set_ex(1, 5, MEM_TO_REG, 32'h100, 0, 1, 0, F3_LW, 32'h4004, 1);
    step;
    checks++;
    if ({dbus.req, dbus.we, dbus.addr, mem_stall} !== {1'b1, 1'b0, 32'h100, 1'b1})
      $display("FAIL lw_issue: req=%b we=%b addr=%h stall=%b expected 1 0 00000100 1", dbus.req, dbus.we, dbus.addr, mem_stall);
    else passed++;
    run_txn(3, 32'hDEADBEEF, stalls, stable, wb);
    checks++;
    if (stalls !== 3 || !stable || wb) $display("FAIL lw_stall: stalls=%0d stable=%b wen_in_bus=%b expected 3 1 0", stalls, stable, wb);
    else passed++;
    checks++;
    if ({mem_read_data, mem_regfile_wr_enable, mem_rd, mem_stall, dbus.req} !== {32'hDEADBEEF, 1'b1, 5'd5, 1'b0, 1'b0})
      $display("FAIL lw_result: data=%h wen=%b rd=%0d stall=%b req=%b expected deadbeef 1 5 0 0",
               mem_read_data, mem_regfile_wr_enable, mem_rd, mem_stall, dbus.req);
    else passed++;
    last_rd = 32'hDEADBEEF;
    bubble;
    step;
  endtask

  task automatic test_sub_word_loads;
    logic [2:0] f3s [4] = '{F3_LB, F3_LBU, F3_LH, F3_LHU};
    logic [31:0] addrs [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] datas [4] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80FF1234, 32'h80FF1234};
    logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    int stalls; logic stable, wb;
    for (int i = 0; i < 4; i++) begin
      set_ex(1, 9, MEM_TO_REG, addrs[i], 0, 1, 0, f3s[i], 0, 1);
      step;
      run_txn(1, datas[i], stalls, stable, wb);
      checks++;
      if (mem_read_data !== exps[i] || stalls !== 1)
        $display("FAIL subword_load[%0d]: data=%h stalls=%0d expected %h 1", i, mem_read_data, stalls, exps[i]);
      else passed++;
      last_rd = exps[i];
      bubble;
      step;
    end
  endtask

  task automatic test_sh;
    int stalls; logic stable, wb;
    set_ex(1, 0, ALU_RESULT, 32'h102, 32'h0000ABCD, 0, 1, F3_SH, 0, 0);
    step;
    checks++;
    if ({dbus.req, dbus.we, dbus.addr, dbus.be, dbus.wdata, mem_regfile_wr_enable} !==
        {1'b1, 1'b1, 32'h100, 4'b1100, 32'hABCDABCD, 1'b0})
      $display("FAIL sh_issue: req=%b we=%b addr=%h be=%b wdata=%h wen=%b expected 1 1 00000100 1100 abcdabcd 0",
               dbus.req, dbus.we, dbus.addr, dbus.be, dbus.wdata, mem_regfile_wr_enable);
    else passed++;
    run_txn(2, 32'hFFFFFFFF, stalls, stable, wb);
    checks++;
    if (stalls !== 2 || !stable || wb || mem_read_data !== last_rd)
      $display("FAIL sh_txn: stalls=%0d stable=%b wen=%b data=%h expected 2 1 0 %h", stalls, stable, wb, mem_read_data, last_rd);
    else passed++;
    bubble;
    step;
  endtask

  task automatic test_misaligned;
    set_ex(1, 3, MEM_TO_REG, 32'h101, 0, 1, 0, F3_LW, 0, 1);
    step;
    checks++;
    if ({dbus.req, mem_misaligned, mem_stall, mem_regfile_wr_enable} !== 4'b0100)
      $display("FAIL misaligned: req=%b mis=%b stall=%b wen=%b expected 0 1 0 0", dbus.req, mem_misaligned, mem_stall, mem_regfile_wr_enable);
    else passed++;
    bubble;
    dbus.ack = 1; dbus.rdata = 32'h55555555;
    step;
    dbus.ack = 0;
    checks++;
    if ({mem_misaligned, mem_stall, dbus.req} !== 3'b000 || mem_read_data !== last_rd)
      $display("FAIL idle_ack: mis=%b stall=%b req=%b data=%h expected 0 0 0 %h", mem_misaligned, mem_stall, dbus.req, mem_read_data, last_rd);
    else passed++;
  endtask

  task automatic test_reset_mid_bus;
    set_ex(1, 6, MEM_TO_REG, 32'h200, 0, 1, 0, F3_LW, 0, 1);
    step;
    step;
    rst_n = 0;
    #1;
    checks++;
    if ({dbus.req, mem_stall, mem_read_data, mem_rd, mem_alu_result, mem_regfile_wr_enable, mem_misaligned} !== '0)
      $display("FAIL reset_mid_bus: req=%b stall=%b data=%h rd=%0d alu=%h", dbus.req, mem_stall, mem_read_data, mem_rd, mem_alu_result);
    else passed++;
    last_rd = 0;
    bubble;
    step;
    step;
    rst_n = 1;
    step;
    step;
    dbus.ack = 1; dbus.rdata = 32'hCAFEF00D;
    step;
    dbus.ack = 0;
    checks++;
    if ({mem_stall, dbus.req, mem_regfile_wr_enable} !== 3'b000 || mem_read_data !== 32'h0)
      $display("FAIL late_ack: stall=%b req=%b wen=%b data=%h expected 0 0 0 00000000", mem_stall, dbus.req, mem_regfile_wr_enable, mem_read_data);
    else passed++;
  endtask

  task automatic test_back_to_back;
    set_ex(1, 7, ALU_RESULT, 32'h1111, 0, 0, 0, 0, 32'h2004, 1);
    step;
    checks++;
    if ({mem_rd, mem_stall, mem_regfile_wr_enable, mem_alu_result} !== {5'd7, 1'b0, 1'b1, 32'h1111})
      $display("FAIL b2b_first: rd=%0d stall=%b wen=%b alu=%h expected 7 0 1 00001111", mem_rd, mem_stall, mem_regfile_wr_enable, mem_alu_result);
    else passed++;
    set_ex(1, 8, PC_PLUS, 32'h2222, 0, 0, 0, 0, 32'h2008, 1);
    step;
    checks++;
    if ({mem_rd, mem_stall, mem_result_src, mem_instr_addr_plus} !== {5'd8, 1'b0, PC_PLUS, 32'h2008})
      $display("FAIL b2b_second: rd=%0d stall=%b src=%0d pc4=%h expected 8 0 2 00002008", mem_rd, mem_stall, mem_result_src, mem_instr_addr_plus);
    else passed++;
    bubble;
    step;
  endtask

  task automatic test_random;
    int stalls; logic stable, wb;
    for (int n = 0; n < 60; n++) begin
      int kind = $urandom_range(0, 3);
      int lat = $urandom_range(1, 4);
      logic [31:0] a = $urandom;
      logic [31:0] wd = $urandom;
      logic [31:0] rdata = $urandom;
      logic [2:0] f3 = (kind == 2) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      logic [4:0] rd = 5'($urandom);
      logic we = (kind == 2) ? 1'b0 : 1'($urandom);
      logic both = 1'($urandom);
      if (kind != 0 && $urandom_range(0, 1) == 1) a = a - a % ref_size(f3);
      set_ex(kind != 3, rd, kind == 1 ? MEM_TO_REG : ALU_RESULT, a, wd, kind == 1 || (kind == 2 && both),
             kind == 2, f3, a + 4, we);
      step;
      if (kind == 3) begin
        checks++;
        if ({mem_regfile_wr_enable, mem_stall, dbus.req, mem_misaligned} !== 4'b0000)
          $display("FAIL rnd_bubble[%0d]: wen=%b stall=%b req=%b mis=%b", n, mem_regfile_wr_enable, mem_stall, dbus.req, mem_misaligned);
        else passed++;
      end else if (kind == 0) begin
        checks++;
        if ({mem_rd, mem_alu_result, mem_regfile_wr_enable, mem_stall, dbus.req} !== {rd, a, we, 1'b0, 1'b0})
          $display("FAIL rnd_alu[%0d]: rd=%0d alu=%h wen=%b stall=%b expected %0d %h %b 0", n, mem_rd, mem_alu_result,
                   mem_regfile_wr_enable, mem_stall, rd, a, we);
        else passed++;
      end else if (ref_mis(a, f3)) begin
        checks++;
        if ({dbus.req, mem_misaligned, mem_stall, mem_regfile_wr_enable} !== 4'b0100)
          $display("FAIL rnd_mis[%0d]: req=%b mis=%b stall=%b wen=%b expected 0 1 0 0", n, dbus.req, mem_misaligned, mem_stall, mem_regfile_wr_enable);
        else passed++;
      end else begin
        checks++;
        if ({dbus.req, dbus.we, dbus.addr} !== {1'b1, kind == 2, a & 32'hFFFFFFFC} ||
            (kind == 2 && {dbus.be, dbus.wdata} !== {ref_be(a, f3), ref_wdata(wd, f3)}))
          $display("FAIL rnd_issue[%0d]: req=%b we=%b addr=%h be=%b wdata=%h expected be=%b wdata=%h", n, dbus.req, dbus.we,
                   dbus.addr, dbus.be, dbus.wdata, ref_be(a, f3), ref_wdata(wd, f3));
        else passed++;
        run_txn(lat, rdata, stalls, stable, wb);
        if (kind == 1) last_rd = ref_load(a, f3, rdata);
        checks++;
        if (stalls !== lat || !stable || wb || mem_read_data !== last_rd ||
            mem_regfile_wr_enable !== we || mem_stall !== 1'b0)
          $display("FAIL rnd_txn[%0d]: stalls=%0d stable=%b data=%h wen=%b expected %0d 1 %h %b", n, stalls, stable,
                   mem_read_data, mem_regfile_wr_enable, lat, last_rd, we);
        else passed++;
      end
    end
    bubble;
    step;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_lw_latency;
    test_sub_word_loads;
    test_sh;
    test_misaligned;
    test_reset_mid_bus;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
